// File: rtl/pla_bist_pkg.sv
// Shared definitions for the PLA sweep/MISR BIST wrapper: MISR constants,
// sweep state type and a one-step MISR helper usable outside the RTL.
package pla_bist_pkg;

    localparam logic [23:0] MISR_POLY_24 = 24'h80_0057;
    localparam logic [23:0] MISR_SEED    = 24'h00_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } pla_state_e;

    // One MISR step: shift left, fold in the polynomial when the MSB falls out.
    function automatic logic [23:0] misr_next(input logic [23:0] sig,
                                              input logic [23:0] z,
                                              input logic [23:0] poly = MISR_POLY_24);
        return {sig[22:0], 1'b0} ^ (sig[23] ? poly : 24'h0) ^ z;
    endfunction

endpackage

// File: rtl/pla_misr.sv
// Multiple-input signature register: load restores the seed, en folds one
// response word into the running signature.
module pla_misr #(
    parameter int           W    = 24,
    parameter logic [W-1:0] POLY = '0,
    parameter logic [W-1:0] SEED = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] sig
);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            sig <= SEED;
        end else if (en) begin
            sig <= {sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : '0) ^ din;
        end
    end

endmodule

// File: rtl/pla_sweep_misr.sv
// Exhaustive PLA sweep engine: drives every input vector, compresses the
// responses into a MISR and compares the result with a golden signature.
module pla_sweep_misr #(
    parameter int               IN_W      = 7,
    parameter int               OUT_W     = 24,
    parameter int               DUT_LAT   = 0,
    parameter logic [OUT_W-1:0] MISR_POLY = pla_bist_pkg::MISR_POLY_24,
    parameter logic [OUT_W-1:0] MISR_SEED = pla_bist_pkg::MISR_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [IN_W-1:0]  x_out,
    input  logic [OUT_W-1:0] z_in,
    input  logic [OUT_W-1:0] expected_sig,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] signature,
    output logic             sig_valid,
    output logic             pass
);

    import pla_bist_pkg::*;

    localparam logic [IN_W-1:0] LAST_VEC = '1;

    pla_state_e      state;
    logic [IN_W-1:0] cnt;
    logic [1:0]      dcnt;
    logic            running;
    logic            kill;
    logic            cap_en;

    assign running = (state == SWEEP) || (state == DRAIN);
    assign kill    = abort && running;
    assign busy    = running;
    assign done    = (state == DONE);
    assign x_out   = running ? cnt : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            dcnt      <= '0;
            sig_valid <= 1'b0;
            pass      <= 1'b0;
        end else if (kill) begin
            state <= IDLE;
            cnt   <= '0;
            dcnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SWEEP;
                        cnt       <= '0;
                        sig_valid <= 1'b0;
                        pass      <= 1'b0;
                    end
                end
                SWEEP: begin
                    if (cnt == LAST_VEC) begin
                        dcnt  <= '0;
                        state <= (DUT_LAT > 0) ? DRAIN : DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (dcnt == 2'(DUT_LAT - 1)) begin
                        state <= DONE;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    sig_valid <= 1'b1;
                    pass      <= (signature == expected_sig);
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The valid pipe mirrors the PLA latency so each vector is captured exactly once.
    generate
        if (DUT_LAT == 0) begin : g_comb
            assign cap_en = (state == SWEEP);
        end else begin : g_pipe
            logic [DUT_LAT-1:0] vpipe;
            always_ff @(posedge clk) begin
                if (rst || kill) begin
                    vpipe <= '0;
                end else begin
                    vpipe[0] <= (state == SWEEP);
                    for (int i = 1; i < DUT_LAT; i++) begin
                        vpipe[i] <= vpipe[i-1];
                    end
                end
            end
            assign cap_en = vpipe[DUT_LAT-1];
        end
    endgenerate

    pla_misr #(
        .W    (OUT_W),
        .POLY (MISR_POLY),
        .SEED (MISR_SEED)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .load (state == IDLE && start),
        .en   (cap_en && !kill),
        .din  (z_in),
        .sig  (signature)
    );

endmodule

// File: tb/tb_pla_sweep_misr.sv
// Scoreboard bench for pla_sweep_misr: one combinational-PLA instance and one
// behind a 2-stage registered PLA, both checked against a signature model.
module tb_pla_sweep_misr;

    import pla_bist_pkg::*;

    localparam int NVEC = 128;

    typedef struct {
        int          due;
        logic [23:0] sig;
        logic        pas;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [23:0] expected_sig;

    logic [6:0]  x0, x2;
    logic [23:0] z0, z2, sig0, sig2;
    logic        busy0, busy2, done0, done2, sv0, sv2, pass0, pass2;

    logic [23:0] pla_tab [NVEC];
    logic [23:0] r1, r2;

    exp_t q0[$];
    exp_t q2[$];
    bit   pend [2];
    logic pend_pass [2];

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    logic [23:0] gold;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign z0 = pla_tab[x0];
    always @(posedge clk) begin
        r1 <= pla_tab[x2];
        r2 <= r1;
    end
    assign z2 = r2;

    pla_sweep_misr #(.DUT_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .x_out(x0), .z_in(z0), .expected_sig(expected_sig),
        .busy(busy0), .done(done0), .signature(sig0),
        .sig_valid(sv0), .pass(pass0)
    );

    pla_sweep_misr #(.DUT_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .x_out(x2), .z_in(z2), .expected_sig(expected_sig),
        .busy(busy2), .done(done2), .signature(sig2),
        .sig_valid(sv2), .pass(pass2)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Signature as polynomial arithmetic: multiply by x modulo the feedback polynomial, add the response.
    function automatic logic [23:0] refStep(input logic [23:0] s, input logic [23:0] z);
        logic [24:0] t;
        t = {s, 1'b0};
        if (t[24]) t = t ^ {1'b1, MISR_POLY_24};
        return t[23:0] ^ z;
    endfunction

    function automatic logic [23:0] refSig();
        logic [23:0] s;
        s = MISR_SEED;
        for (int k = 0; k < NVEC; k++) s = refStep(s, pla_tab[k]);
        return s;
    endfunction

    task automatic monitorStep(input int i, input logic dn, input logic [23:0] s,
                               input logic sv, input logic ps);
        exp_t  e;
        string tag;
        int    qn;
        tag = (i == 0) ? "lat0" : "lat2";
        qn  = (i == 0) ? q0.size() : q2.size();
        if (pend[i]) begin
            checkOutput({tag, "_sig_valid"}, 32'(sv), 32'd1);
            checkOutput({tag, "_pass"}, 32'(ps), 32'(pend_pass[i]));
            pend[i] = 1'b0;
        end
        if (dn) begin
            if (qn == 0) begin
                checkOutput({tag, "_unexpected_done"}, 32'd1, 32'd0);
            end else begin
                if (i == 0) e = q0.pop_front(); else e = q2.pop_front();
                checkOutput({tag, "_done_cycle"}, 32'(cyc), 32'(e.due));
                checkOutput({tag, "_signature"}, 32'(s), 32'(e.sig));
                pend[i]      = 1'b1;
                pend_pass[i] = e.pas;
            end
        end else if (qn != 0) begin
            if (i == 0) e = q0[0]; else e = q2[0];
            if (cyc > e.due) begin
                checkOutput({tag, "_done_missing"}, 32'd0, 32'd1);
                if (i == 0) void'(q0.pop_front()); else void'(q2.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        monitorStep(0, done0, sig0, sv0, pass0);
        monitorStep(1, done2, sig2, sv2, pass2);
    end

    // Called on a falling edge; an accepted start schedules one done per instance.
    task automatic applyStimulus(input bit do_start, input bit do_abort);
        exp_t e;
        start = do_start;
        abort = do_abort;
        if (do_start) begin
            e.sig = refSig();
            e.pas = (e.sig == expected_sig);
            e.due = cyc + NVEC + 1;
            q0.push_back(e);
            e.due = cyc + NVEC + 3;
            q2.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while ((q0.size() != 0 || q2.size() != 0 || pend[0] || pend[1]) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) checkOutput("wait_idle_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic runSweep(input bit with_abort, input int p1, input int p2);
        applyStimulus(1'b1, with_abort);
        checkOutput("busy_after_start", 32'({busy0, busy2}), 32'd3);
        for (int k = 0; k < NVEC; k++) begin
            checkOutput("x0_step", 32'(x0), 32'(k));
            checkOutput("x2_step", 32'(x2), 32'(k));
            start = (k == p1) || (k == p2);
            @(negedge clk);
        end
        start = 1'b0;
        waitIdle(400);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_x_out"}, 32'({x0, x2}), 32'd0);
        checkOutput({tag, "_busy"}, 32'({busy0, busy2}), 32'd0);
        checkOutput({tag, "_done"}, 32'({done0, done2}), 32'd0);
        checkOutput({tag, "_sig_valid"}, 32'({sv0, sv2}), 32'd0);
        checkOutput({tag, "_pass"}, 32'({pass0, pass2}), 32'd0);
        checkOutput({tag, "_sig0"}, 32'(sig0), 32'(MISR_SEED));
        checkOutput({tag, "_sig2"}, 32'(sig2), 32'(MISR_SEED));
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        logic [23:0] a, b;
        rst = 1'b1; start = 1'b0; abort = 1'b0; expected_sig = '0;
        for (int k = 0; k < NVEC; k++) pla_tab[k] = '0;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] all-zero responses, golden signature 0");
        runSweep(1'b0, -1, -1);

        for (int i = 0; i < 6; i++) begin
            a = 24'($urandom); b = 24'($urandom);
            checkOutput("pkg_misr_next", 32'(misr_next(a, b)), 32'(refStep(a, b)));
        end

        for (int k = 0; k < NVEC; k++) pla_tab[k] = 24'($urandom);
        gold = refSig();
        expected_sig = gold;
        $display("[TB] random PLA, start together with abort in IDLE");
        runSweep(1'b1, -1, -1);

        $display("[TB] start coinciding with done is ignored");
        applyStimulus(1'b1, 1'b0);
        n = 0;
        while (!done0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("done0_seen", 32'(done0), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("start_at_done_ignored", 32'(busy0), 32'd0);
        waitIdle(400);

        $display("[TB] corrupted golden signature");
        expected_sig = gold ^ 24'h1;
        runSweep(1'b0, -1, -1);
        expected_sig = gold;

        $display("[TB] repeated start mid-sweep");
        runSweep(1'b0, 10, 100);

        $display("[TB] abort at vector 50");
        applyStimulus(1'b1, 1'b0);
        repeat (50) @(negedge clk);
        checkOutput("x0_before_abort", 32'(x0), 32'd50);
        abort = 1'b1;
        q0.delete(); q2.delete();
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_busy", 32'({busy0, busy2}), 32'd0);
        checkOutput("abort_x_out", 32'({x0, x2}), 32'd0);
        checkOutput("abort_sig_valid", 32'({sv0, sv2}), 32'd0);
        repeat (140) @(negedge clk);
        checkOutput("abort_still_idle", 32'({busy0, busy2, sv0, sv2}), 32'd0);
        runSweep(1'b0, -1, -1);

        $display("[TB] reset at vector 64");
        applyStimulus(1'b1, 1'b0);
        repeat (64) @(negedge clk);
        checkOutput("x0_before_rst", 32'(x0), 32'd64);
        rst = 1'b1;
        q0.delete(); q2.delete();
        @(negedge clk);
        rst = 1'b0;
        checkResetValues("midsweep_rst");
        runSweep(1'b0, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
